// File: rtl/spi_pkg.sv
// spi_pkg: shared frame width default and transmitter state encoding.
package spi_pkg;
  localparam int DEF_DATA_W = 24;
  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, TAIL, CS_HI, COMMIT} state_t;
endpackage

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: pulses tick on the last cycle of every CLK_DIV-cycle state.
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (restart) cnt <= W'(CLK_DIV - 1);
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign tick = cnt == '0;
endmodule

// File: rtl/spi_master_tx.sv
// spi_master_tx: shifts a word out MSB first on sck/sda under cs, then issues a commit pulse.
module spi_master_tx import spi_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic              sda,
  output logic              cs
);
  localparam int CW = $clog2(DATA_W);
  state_t state, nxt;
  logic [DATA_W-1:0] sh, sh_nxt;
  logic [CW-1:0] bits, bits_nxt;
  logic tick, adv, cs_low;
  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .restart(adv), .tick(tick));
  always_comb begin
    nxt = state;
    sh_nxt = sh;
    bits_nxt = bits;
    case (state)
      IDLE: if (tx_valid) begin
        nxt = SHIFT_LO;
        sh_nxt = tx_data;
        bits_nxt = CW'(DATA_W - 1);
      end
      SHIFT_LO: if (tick) nxt = SHIFT_HI;
      SHIFT_HI: if (tick) begin
        nxt = bits == '0 ? TAIL : SHIFT_LO;
        sh_nxt = bits == '0 ? sh : sh << 1;
        bits_nxt = bits == '0 ? bits : bits - 1'b1;
      end
      TAIL: if (tick) nxt = CS_HI;
      CS_HI: if (tick) nxt = COMMIT;
      COMMIT: if (tick) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // every transition changes state, so a state change is exactly a divider restart
  assign adv = nxt != state;
  assign cs_low = nxt inside {SHIFT_LO, SHIFT_HI, TAIL};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sh <= '0;
      bits <= '0;
      tx_ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      sck <= 1'b0;
      sda <= 1'b0;
      cs <= 1'b1;
    end else begin
      state <= nxt;
      sh <= sh_nxt;
      bits <= bits_nxt;
      tx_ready <= nxt == IDLE;
      busy <= nxt != IDLE;
      done <= state == COMMIT && nxt == IDLE;
      sck <= nxt == SHIFT_HI || nxt == COMMIT;
      sda <= cs_low && sh_nxt[DATA_W-1];
      cs <= !cs_low;
    end
endmodule

// File: doc/spi_master_tx.md
# spi_master_tx

Serial frame transmitter that drives the three-wire sck/sda/cs register-load interface from the system clock domain. It accepts a 24-bit word over a valid/ready handshake and shifts it out MSB first, with sda stable around every sck rising edge while cs is low. It then raises cs and issues one commit sck pulse, so the far-end shift register is copied into its output register. It sits between the local controller logic and the CPLD pins.

## Interface
- DATA_W, 24, frame width in bits.
- CLK_DIV, 4, clk cycles per sck half-period (D); legal range 1..255.
- clk input 1 system clock; all logic on rising edge.
- rst_n input 1 asynchronous, active-low reset.
- tx_data input DATA_W word to send; sampled only on the accept edge.
- tx_valid input 1 word available.
- tx_ready output 1 high only in IDLE.
- busy output 1 high whenever the state is not IDLE.
- done output 1 one-cycle pulse when the commit pulse completes.
- sck output 1 serial clock, idle low.
- sda output 1 serial data.
- cs output 1 chip select, active low, idle high.

## Operation
- Accept on a clk edge with tx_valid && tx_ready. tx_data is latched into a shift register.
- tx_valid while busy is ignored; the requester holds it until tx_ready.
- States: IDLE → SHIFT_LO → SHIFT_HI (repeated DATA_W times) → TAIL → CS_HI → COMMIT → IDLE.
- SHIFT_LO: sck=0, cs=0, sda = current bit.
- SHIFT_HI: sck=1, bit held.
- Leaving SHIFT_HI with bits remaining: shift left, go to SHIFT_LO. sda changes together with the sck falling edge.
- TAIL: sck=0, cs=0; hold time after the last bit.
- CS_HI: cs=1, sck=0.
- COMMIT: cs=1, sck=1. This one rising edge with cs high loads the far-end output register.
- Each state lasts exactly D clk cycles, timed by a divider tick.
- The bit counter runs DATA_W-1 down to 0.
- In IDLE, sda=0.
- Reset values: cs=1, sck=0, sda=0, busy=0, done=0, tx_ready=1. All outputs are registered.
- Reset mid-frame: cs goes high and sck low immediately. No commit edge is produced, so the far-end output keeps its old value. After reset release the block is in IDLE.

## Timing
- Cycle 0 is the first cycle after the accept edge.
- cs low during cycles [0, 49D).
- Bit n (n=0 is the MSB) is on sda during [2nD, 2nD+2D).
- sck high during [(2n+1)D, (2n+2)D), giving D cycles of setup and D cycles of hold per bit.
- TAIL occupies [48D, 49D).
- cs high from cycle 49D.
- Commit sck high during [50D, 51D).
- At cycle 51D: done=1 for one cycle, tx_ready=1, busy=0. A tx_valid in that same cycle is accepted.
- Frame period: 51D cycles. Back-to-back throughput is one word per 51D cycles.
- sck frequency is clk/(2D). D=1 gives clk/2.

## Structure
- Shared package spi_pkg holds:
  - the DATA_W default (24);
  - the state enum (IDLE, SHIFT_LO, SHIFT_HI, TAIL, CS_HI, COMMIT).
- Sub-module spi_tick_gen: a down-counter of $clog2(CLK_DIV+1) bits that pulses a tick every D cycles. It restarts on every state entry and is cleared by rst_n.
- The FSM, shift register and 5-bit bit counter live in spi_master_tx.

## Test plan
- D=4, send 24'hA5C3_0F:
  - expect 24 sck rising edges with cs low, carrying sda bits 1010_0101_1100_0011_0000_1111 in order;
  - cs rises at cycle 196; commit sck high during cycles 200..203; done at cycle 204.
- Bench model of the far-end receiver: send 24'h123456, then 24'hFFFFFF back-to-back (tx_valid held high). The model output shows 24'h123456, then 24'hFFFFFF. Second accept occurs exactly at cycle 51D.
- Toggle tx_valid and tx_data during a frame → no extra accept; the frame data is unchanged; tx_ready stays 0 until cycle 51D.
- Assert rst_n low at cycle 100 with D=4 → cs=1 and sck=0 asynchronously. The receiver model's output register keeps its previous value. The next frame after release transmits correctly.
- D=1, send 24'h800001 → sck period is 2 clk cycles; first and last data bits are 1; done at cycle 51.
- Idle check: 50 cycles with no tx_valid → cs=1, sck=0, sda=0, busy=0, no done pulse.
